// File: rtl/dma_burst_master.sv
// rtl/dma_burst_master.sv - single-channel AXI memory-to-memory burst DMA engine
module dma_burst_master #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int ID_W      = 4,
    parameter int LEN_W     = 4,
    parameter int MAX_BURST = 16,
    parameter int CNT_W     = 16,
    parameter int MASTER_ID = 0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                dma_start,
    input  logic [ADDR_W-1:0]   dma_src,
    input  logic [ADDR_W-1:0]   dma_dst,
    input  logic [CNT_W-1:0]    dma_len,
    input  logic                dma_clr,
    output logic                dma_busy,
    output logic                dma_done,
    output logic                dma_err,
    output logic [ID_W-1:0]     M_AWID,
    output logic [ADDR_W-1:0]   M_AWAddr,
    output logic [LEN_W-1:0]    M_AWLen,
    output logic [2:0]          M_AWSize,
    output logic [1:0]          M_AWBurst,
    output logic                M_AWValid,
    input  logic                M_AWReady,
    output logic [DATA_W-1:0]   M_WData,
    output logic [DATA_W/8-1:0] M_WStrb,
    output logic                M_WLast,
    output logic                M_WValid,
    input  logic                M_WReady,
    input  logic [ID_W-1:0]     M_BID,
    input  logic [1:0]          M_BResp,
    input  logic                M_BValid,
    output logic                M_BReady,
    output logic [ID_W-1:0]     M_ARID,
    output logic [ADDR_W-1:0]   M_ARAddr,
    output logic [LEN_W-1:0]    M_ARLen,
    output logic [2:0]          M_ARSize,
    output logic [1:0]          M_ARBurst,
    output logic                M_ARValid,
    input  logic                M_ARReady,
    input  logic [ID_W-1:0]     M_RID,
    input  logic [DATA_W-1:0]   M_RData,
    input  logic [1:0]          M_RResp,
    input  logic                M_RLast,
    input  logic                M_RValid,
    output logic                M_RReady
);

    localparam int SZ = $clog2(DATA_W / 8);
    localparam int BW = $clog2(MAX_BURST) + 1;
    localparam int IW = (MAX_BURST > 1) ? $clog2(MAX_BURST) : 1;
    localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'((1 << SZ) - 1);

    typedef enum logic [2:0] {
        S_IDLE, S_CALC, S_RD_ADDR, S_RD_DATA, S_WR_ADDR, S_WR_DATA, S_WR_RESP, S_DONE
    } state_t;

    state_t state, state_nx;

    logic [ADDR_W-1:0] src_q, dst_q;
    logic [CNT_W-1:0]  rem_q;
    logic [BW-1:0]     beats_q, ridx_q, widx_q;
    logic              err_q;
    logic [DATA_W-1:0] buf_mem [MAX_BURST];

    logic [31:0] src_room, dst_room, lim;
    logic        r_fire, w_fire, r_last, w_last;
    logic        unused_ok;

    // Words left before each address crosses into the next 4KB page.
    always_comb begin
        src_room = (32'd4096 - 32'(src_q[11:0])) >> SZ;
        dst_room = (32'd4096 - 32'(dst_q[11:0])) >> SZ;
        lim      = 32'(rem_q);
        if (32'(MAX_BURST) < lim) lim = 32'(MAX_BURST);
        if (src_room < lim)       lim = src_room;
        if (dst_room < lim)       lim = dst_room;
    end

    assign r_fire = (state == S_RD_DATA) && M_RValid;
    assign w_fire = (state == S_WR_DATA) && M_WReady;
    assign r_last = (ridx_q == beats_q - BW'(1));
    assign w_last = (widx_q == beats_q - BW'(1));

    assign M_AWID    = ID_W'(MASTER_ID);
    assign M_ARID    = ID_W'(MASTER_ID);
    assign M_AWSize  = 3'(SZ);
    assign M_ARSize  = 3'(SZ);
    assign M_AWBurst = 2'b01;
    assign M_ARBurst = 2'b01;
    assign M_WStrb   = '1;
    assign dma_busy  = (state != S_IDLE);
    assign dma_done  = (state == S_DONE);
    assign dma_err   = err_q;

    assign unused_ok = ^{M_RID, M_BID, M_RLast, lim[31:BW]};

    always_ff @(posedge clk) begin
        if (!rst) state <= S_IDLE;
        else      state <= state_nx;
    end

    always_comb begin
        state_nx  = state;
        M_ARValid = 1'b0;
        M_ARAddr  = '0;
        M_ARLen   = '0;
        M_RReady  = 1'b0;
        M_AWValid = 1'b0;
        M_AWAddr  = '0;
        M_AWLen   = '0;
        M_WValid  = 1'b0;
        M_WData   = '0;
        M_WLast   = 1'b0;
        M_BReady  = 1'b0;
        case (state)
            S_IDLE: begin
                if (dma_start) state_nx = (dma_len == '0) ? S_DONE : S_CALC;
            end
            S_CALC: state_nx = S_RD_ADDR;
            S_RD_ADDR: begin
                M_ARValid = 1'b1;
                M_ARAddr  = src_q;
                M_ARLen   = LEN_W'(beats_q - BW'(1));
                if (M_ARReady) state_nx = S_RD_DATA;
            end
            S_RD_DATA: begin
                M_RReady = 1'b1;
                if (r_fire && r_last) state_nx = S_WR_ADDR;
            end
            S_WR_ADDR: begin
                M_AWValid = 1'b1;
                M_AWAddr  = dst_q;
                M_AWLen   = LEN_W'(beats_q - BW'(1));
                if (M_AWReady) state_nx = S_WR_DATA;
            end
            S_WR_DATA: begin
                M_WValid = 1'b1;
                M_WData  = buf_mem[widx_q[IW-1:0]];
                M_WLast  = w_last;
                if (w_fire && w_last) state_nx = S_WR_RESP;
            end
            S_WR_RESP: begin
                M_BReady = 1'b1;
                if (M_BValid) state_nx = (rem_q == CNT_W'(beats_q)) ? S_DONE : S_CALC;
            end
            S_DONE: begin
                if (dma_clr) state_nx = S_IDLE;
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            src_q   <= '0;
            dst_q   <= '0;
            rem_q   <= '0;
            beats_q <= '0;
            ridx_q  <= '0;
            widx_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (dma_start) begin
                        src_q <= dma_src & ALIGN_MASK;
                        dst_q <= dma_dst & ALIGN_MASK;
                        rem_q <= dma_len;
                        err_q <= 1'b0;
                    end
                end
                S_CALC: begin
                    beats_q <= BW'(lim);
                    ridx_q  <= '0;
                    widx_q  <= '0;
                end
                S_RD_DATA: begin
                    if (r_fire) begin
                        ridx_q <= ridx_q + BW'(1);
                        if (M_RResp != 2'b00) err_q <= 1'b1;
                    end
                end
                S_WR_DATA: begin
                    if (w_fire) widx_q <= widx_q + BW'(1);
                end
                S_WR_RESP: begin
                    if (M_BValid) begin
                        if (M_BResp != 2'b00) err_q <= 1'b1;
                        src_q <= src_q + ADDR_W'(32'(beats_q) << SZ);
                        dst_q <= dst_q + ADDR_W'(32'(beats_q) << SZ);
                        rem_q <= rem_q - CNT_W'(beats_q);
                    end
                end
                default: ;
            endcase
        end
    end

    // Burst buffer holds data only; it needs no reset.
    always_ff @(posedge clk) begin
        if (r_fire) buf_mem[ridx_q[IW-1:0]] <= M_RData;
    end

endmodule

// File: tb/tb_dma_burst_master.sv
// tb/tb_dma_burst_master.sv - self-checking bench for dma_burst_master
module tb_dma_burst_master;

    logic        clk = 1'b0;
    logic        rst;
    logic        dma_start, dma_clr;
    logic [31:0] dma_src, dma_dst;
    logic [15:0] dma_len;
    logic        dma_busy, dma_done, dma_err;
    logic [3:0]  M_AWID, M_ARID, M_BID, M_RID;
    logic [31:0] M_AWAddr, M_ARAddr, M_WData, M_RData;
    logic [3:0]  M_AWLen, M_ARLen, M_WStrb;
    logic [2:0]  M_AWSize, M_ARSize;
    logic [1:0]  M_AWBurst, M_ARBurst, M_BResp, M_RResp;
    logic        M_AWValid, M_AWReady, M_WLast, M_WValid, M_WReady;
    logic        M_BValid, M_BReady, M_ARValid, M_ARReady, M_RLast, M_RValid, M_RReady;

    always #5 clk = ~clk;

    dma_burst_master dut (
        .clk(clk), .rst(rst), .dma_start(dma_start), .dma_src(dma_src), .dma_dst(dma_dst),
        .dma_len(dma_len), .dma_clr(dma_clr), .dma_busy(dma_busy), .dma_done(dma_done),
        .dma_err(dma_err), .M_AWID(M_AWID), .M_AWAddr(M_AWAddr), .M_AWLen(M_AWLen),
        .M_AWSize(M_AWSize), .M_AWBurst(M_AWBurst), .M_AWValid(M_AWValid), .M_AWReady(M_AWReady),
        .M_WData(M_WData), .M_WStrb(M_WStrb), .M_WLast(M_WLast), .M_WValid(M_WValid),
        .M_WReady(M_WReady), .M_BID(M_BID), .M_BResp(M_BResp), .M_BValid(M_BValid),
        .M_BReady(M_BReady), .M_ARID(M_ARID), .M_ARAddr(M_ARAddr), .M_ARLen(M_ARLen),
        .M_ARSize(M_ARSize), .M_ARBurst(M_ARBurst), .M_ARValid(M_ARValid), .M_ARReady(M_ARReady),
        .M_RID(M_RID), .M_RData(M_RData), .M_RResp(M_RResp), .M_RLast(M_RLast),
        .M_RValid(M_RValid), .M_RReady(M_RReady)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] src_word(input logic [31:0] a);
        return a * 32'h9E3779B1 + 32'h01234567;
    endfunction

    typedef struct packed { logic [31:0] a; logic [31:0] n; } req_t;
    typedef struct packed { logic [31:0] s; logic [31:0] d; logic [31:0] n; } burst_t;

    req_t   ar_obs[$];
    req_t   aw_obs[$];
    burst_t exp_q[$];
    logic [31:0] wmem [logic [31:0]];

    int stall_pct = 0;
    int rbad_g = -1;
    int bbad_g = -1;
    int r_cnt, b_cnt;
    logic [31:0] cur_src, cur_dst;
    int cur_len;

    // Slave-side bookkeeping (owned by the slave process)
    logic [31:0] r_addr, w_addr;
    int r_left, w_left;
    logic b_pending;
    logic ar_st, aw_st, w_st;
    logic [35:0] ar_h, aw_h;
    logic [32:0] w_h;

    function automatic logic rdy();
        return $urandom_range(99) >= stall_pct;
    endfunction

    // Behavioural AXI slave: memory-backed reads, scoreboarded writes.
    initial begin
        M_ARReady = 0; M_AWReady = 0; M_WReady = 0; M_RValid = 0; M_BValid = 0;
        M_RData = 0; M_RResp = 0; M_RLast = 0; M_BResp = 0; M_RID = 0; M_BID = 0;
        r_left = 0; w_left = 0; b_pending = 0; ar_st = 0; aw_st = 0; w_st = 0;
        forever begin
            @(negedge clk); #1;
            if (!rst) begin
                r_left = 0; w_left = 0; b_pending = 0; ar_st = 0; aw_st = 0; w_st = 0;
                M_ARReady = 0; M_AWReady = 0; M_WReady = 0; M_RValid = 0; M_BValid = 0;
                continue;
            end
            M_ARReady = rdy();
            M_AWReady = rdy();
            M_WReady  = rdy();
            M_RValid  = (r_left > 0) && rdy();
            M_RData   = src_word(r_addr);
            M_RResp   = (r_cnt == rbad_g) ? 2'b10 : 2'b00;
            M_RLast   = (r_left == 1);
            M_BValid  = b_pending;
            M_BResp   = (b_cnt == bbad_g) ? 2'b10 : 2'b00;
            #1;
            if (ar_st) chk("ar_hold", {M_ARValid, M_ARAddr, M_ARLen}, {1'b1, ar_h});
            if (aw_st) chk("aw_hold", {M_AWValid, M_AWAddr, M_AWLen}, {1'b1, aw_h});
            if (w_st)  chk("w_hold", {M_WValid, M_WData, M_WLast}, {1'b1, w_h});
            ar_st = M_ARValid && !M_ARReady; ar_h = {M_ARAddr, M_ARLen};
            aw_st = M_AWValid && !M_AWReady; aw_h = {M_AWAddr, M_AWLen};
            w_st  = M_WValid && !M_WReady;   w_h  = {M_WData, M_WLast};
            if (M_ARValid && M_ARReady) begin
                ar_obs.push_back({M_ARAddr, 28'd0, M_ARLen});
                chk("ar_const", {M_ARID, M_ARSize, M_ARBurst}, {4'd0, 3'd2, 2'b01});
                r_addr = M_ARAddr; r_left = int'(M_ARLen) + 1;
            end
            if (M_RValid) begin
                chk("rready", M_RReady, 1);
                if (M_RReady) begin r_addr += 4; r_left--; r_cnt++; end
            end
            if (M_AWValid && M_AWReady) begin
                aw_obs.push_back({M_AWAddr, 28'd0, M_AWLen});
                chk("aw_const", {M_AWID, M_AWSize, M_AWBurst}, {4'd0, 3'd2, 2'b01});
                w_addr = M_AWAddr; w_left = int'(M_AWLen) + 1;
            end
            if (M_WValid) chk("w_after_aw", w_left > 0, 1);
            if (M_WValid && M_WReady && w_left > 0) begin
                chk("wlast", M_WLast, w_left == 1);
                chk("wstrb", M_WStrb, 4'hF);
                wmem[w_addr] = M_WData;
                w_addr += 4; w_left--;
                if (w_left == 0) b_pending = 1;
            end
            if (M_BValid && M_BReady) begin b_pending = 0; b_cnt++; end
        end
    end

    // Reference: split the copy into bursts from the page/size/remaining rules.
    task automatic build_model(input logic [31:0] s0, input logic [31:0] d0, input int len);
        logic [31:0] s, d;
        int rem, b, rs, rd;
        s = s0 & ~32'd3; d = d0 & ~32'd3; rem = len;
        exp_q.delete();
        while (rem > 0) begin
            rs = (4096 - int'(s[11:0])) / 4;
            rd = (4096 - int'(d[11:0])) / 4;
            b = rem;
            if (16 < b) b = 16;
            if (rs < b) b = rs;
            if (rd < b) b = rd;
            exp_q.push_back({s, d, 32'(b)});
            s += 32'(b * 4); d += 32'(b * 4); rem -= b;
        end
    endtask

    task automatic begin_xfer(input logic [31:0] s, input logic [31:0] d, input int len,
                              input int stall, input int rbad, input int bbad);
        ar_obs.delete(); aw_obs.delete(); wmem.delete();
        r_cnt = 0; b_cnt = 0; stall_pct = stall; rbad_g = rbad; bbad_g = bbad;
        cur_src = s & ~32'd3; cur_dst = d & ~32'd3; cur_len = len;
        build_model(s, d, len);
        dma_src = s; dma_dst = d; dma_len = 16'(len); dma_start = 1;
        @(negedge clk);
        dma_start = 0;
    endtask

    task automatic end_xfer(input string nm, input int exp_bursts, input int exp_err);
        int cyc, mis, e;
        cyc = 0;
        while (dma_done !== 1'b1 && cyc < 5000) begin @(negedge clk); cyc++; end
        chk({nm, "_done"}, dma_done, 1);
        chk({nm, "_busy"}, dma_busy, 1);
        chk({nm, "_n_ar"}, ar_obs.size(), exp_q.size());
        chk({nm, "_n_aw"}, aw_obs.size(), exp_q.size());
        if (exp_bursts >= 0) chk({nm, "_n_tbl"}, ar_obs.size(), exp_bursts);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < ar_obs.size())
                chk($sformatf("%s_ar%0d", nm, i), {ar_obs[i].a, ar_obs[i].n},
                    {exp_q[i].s, exp_q[i].n - 32'd1});
            if (i < aw_obs.size())
                chk($sformatf("%s_aw%0d", nm, i), {aw_obs[i].a, aw_obs[i].n},
                    {exp_q[i].d, exp_q[i].n - 32'd1});
        end
        mis = 0;
        for (int i = 0; i < cur_len; i++) begin
            logic [31:0] a;
            a = cur_dst + 32'(4 * i);
            if (!wmem.exists(a)) mis++;
            else if (wmem[a] !== src_word(cur_src + 32'(4 * i))) mis++;
        end
        chk({nm, "_data"}, mis, 0);
        e = exp_err;
        if (e < 0) e = ((rbad_g >= 0 && rbad_g < cur_len) ||
                        (bbad_g >= 0 && bbad_g < exp_q.size())) ? 1 : 0;
        chk({nm, "_err"}, dma_err, e);
    endtask

    task automatic clr_done();
        dma_clr = 1;
        @(negedge clk);
        dma_clr = 0;
        chk("clr_idle", {dma_busy, dma_done}, 2'b00);
    endtask

    typedef struct {
        logic [31:0] src;
        logic [31:0] dst;
        int len, stall, rbad, bbad, exp_bursts, exp_err;
    } vec_t;
    vec_t vecs[6];

    initial begin
        int cyc;
        logic [31:0] s, d;
        int len, rb, bb;

        vecs[0] = '{32'h1000, 32'h2000, 4, 0, -1, -1, 1, 0};
        vecs[1] = '{32'h0000, 32'h8000, 40, 0, -1, -1, 3, 0};
        vecs[2] = '{32'h0FF8, 32'h4000, 8, 0, -1, -1, 2, 0};
        vecs[3] = '{32'h3000, 32'h5004, 20, 50, -1, -1, 2, 0};
        vecs[4] = '{32'h0100, 32'h0200, 10, 20, 3, -1, 1, 1};
        vecs[5] = '{32'h2FF0, 32'h7FFC, 6, 0, -1, 1, 3, 1};

        rst = 0; dma_start = 0; dma_clr = 0; dma_src = 0; dma_dst = 0; dma_len = 0;
        repeat (3) @(negedge clk);
        chk("rst_ctl", {M_ARValid, M_RReady, M_AWValid, M_WValid, M_BReady,
                        dma_busy, dma_done, dma_err}, 0);
        chk("rst_addr", {M_ARAddr, M_AWAddr}, 0);
        chk("rst_data", {M_WData, M_ARLen, M_AWLen}, 0);
        rst = 1;
        @(negedge clk);

        foreach (vecs[i]) begin
            begin_xfer(vecs[i].src, vecs[i].dst, vecs[i].len, vecs[i].stall,
                       vecs[i].rbad, vecs[i].bbad);
            end_xfer($sformatf("vec%0d", i), vecs[i].exp_bursts, vecs[i].exp_err);
            clr_done();
        end
        chk("err_sticky", dma_err, 1);

        // len=0 goes straight to DONE and clears the previous error
        begin_xfer(32'h500, 32'h600, 0, 0, -1, -1);
        chk("len0_done", {dma_done, dma_err}, 2'b10);
        repeat (2) @(negedge clk);
        chk("len0_no_ar", ar_obs.size() + aw_obs.size(), 0);
        chk("len0_hold", dma_done, 1);
        clr_done();

        // start while busy is ignored; start in DONE ignored; clr wins over start
        begin_xfer(32'h400, 32'h600, 20, 10, -1, -1);
        repeat (3) @(negedge clk);
        dma_src = 32'h9000; dma_dst = 32'hA000; dma_len = 3; dma_start = 1;
        @(negedge clk);
        dma_start = 0;
        end_xfer("busy_start", 2, 0);
        dma_start = 1;
        @(negedge clk);
        dma_start = 0;
        chk("start_in_done", {dma_done, M_ARValid}, 2'b10);
        dma_start = 1; dma_clr = 1;
        @(negedge clk);
        dma_start = 0; dma_clr = 0;
        chk("clr_priority", {dma_busy, dma_done}, 2'b00);
        @(negedge clk);
        chk("clr_stays_idle", dma_busy, 0);

        // reset during WR_DATA abandons the transfer
        begin_xfer(32'h1000, 32'h2000, 16, 30, -1, -1);
        cyc = 0;
        while (M_WValid !== 1'b1 && cyc < 2000) begin @(negedge clk); cyc++; end
        chk("reach_wdata", M_WValid, 1);
        rst = 0;
        @(negedge clk);
        chk("midrst_outs", {M_ARValid, M_AWValid, M_WValid, M_RReady, M_BReady, dma_busy}, 0);
        rst = 1;
        @(negedge clk);
        chk("midrst_idle", {M_ARValid, M_AWValid, M_WValid, dma_busy}, 0);
        begin_xfer(32'h1FF0, 32'h3000, 12, 25, -1, -1);
        end_xfer("after_rst", 2, 0);
        clr_done();

        // randomized transfers against the burst-splitting model
        for (int k = 0; k < 20; k++) begin
            s = $urandom_range(0, 32'h3FFF);
            d = 32'h10000 + $urandom_range(0, 32'h3FFF);
            if ($urandom_range(1) == 1) s = 32'h1000 * $urandom_range(1, 3) - 4 * $urandom_range(1, 20);
            if ($urandom_range(1) == 1) d = 32'h11000 - 4 * $urandom_range(1, 20);
            len = $urandom_range(1, 60);
            rb = ($urandom_range(3) == 0) ? $urandom_range(0, len - 1) : -1;
            bb = ($urandom_range(3) == 0) ? 0 : -1;
            begin_xfer(s, d, len, $urandom_range(0, 60), rb, bb);
            end_xfer($sformatf("rnd%0d", k), -1, -1);
            clr_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
